// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide sequencer for the pipelined mips core.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO
// architectural registers. Multiply/divide results are computed when the op
// is accepted, parked in t_hi/t_lo, and committed to HI/LO after a fixed
// busy period, which models the latency of an iterative unit. Also produces
// the D-stage freeze request for HI/LO-dependent instructions.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   start   in   E-stage instruction is an MDU op (single-cycle pulse)
//   op      in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b    in   rs / rt operands
//   md_use  in   D-stage instruction touches the MDU or HI/LO
//   busy    out  a multi-cycle op is in flight (decoded from state flop)
//   stall   out  md_use & (busy | start), combinational
//   hi, lo  out  HI / LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] t_hi, t_lo, t_hi_next, t_lo_next;
  logic [31:0] hi_next, lo_next;

  // ---------------------------------------------------------------------------
  // Result datapath. Division runs on 33-bit sign-extended operands so that
  // 0x80000000 / -1 yields +2^31 without overflow; its low word is the
  // architecturally expected 0x80000000. The divisor is forced non-zero so a
  // zero divide never produces X; that result is discarded anyway.
  // ---------------------------------------------------------------------------
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        div_b;
  logic signed [32:0] a_s, b_s, quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_zero;

  assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u   = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);
  assign div_b    = div_zero ? 32'd1 : b;
  assign a_s      = $signed({a[31], a});
  assign b_s      = $signed({div_b[31], div_b});
  assign quot_s   = a_s / b_s;
  assign rem_s    = a_s % b_s;
  assign quot_u   = a / div_b;
  assign rem_u    = a % div_b;

  // ---------------------------------------------------------------------------
  // State register (includes counter, temps and HI/LO).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      t_hi  <= 32'd0;
      t_lo  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      t_hi  <= t_hi_next;
      t_lo  <= t_lo_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Any start arriving in RUN is ignored.
  // NOTE: every signal gets a hold default up front so no path leaves it
  // unassigned, which would otherwise infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    t_hi_next  = t_hi;
    t_lo_next  = t_lo;
    hi_next    = hi;
    lo_next    = lo;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              t_hi_next  = prod_s[63:32];
              t_lo_next  = prod_s[31:0];
              cnt_next   = MULT_LOAD;
              state_next = S_RUN;
            end
            OP_MULTU: begin
              t_hi_next  = prod_u[63:32];
              t_lo_next  = prod_u[31:0];
              cnt_next   = MULT_LOAD;
              state_next = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero keeps the current HI/LO, so park them in the
              // temps and let the normal commit write them back unchanged.
              if (div_zero) begin
                t_hi_next = hi;
                t_lo_next = lo;
              end else if (op == OP_DIV) begin
                t_hi_next = rem_s[31:0];
                t_lo_next = quot_s[31:0];
              end else begin
                t_hi_next = rem_u;
                t_lo_next = quot_u;
              end
              cnt_next   = DIV_LOAD;
              state_next = S_RUN;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;  // reserved encodings have no effect
          endcase
        end
      end
      S_RUN: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_next    = t_hi;
          lo_next    = t_lo;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. busy comes straight from the state flop, so it is registered.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state == S_RUN);
    stall = md_use & (busy | start);
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl (default parameters).
// Inputs are driven just after the falling edge and outputs sampled at the
// falling edge, half a period away from the active rising edge. A reference
// model computes HI/LO and the busy length from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .md_use(md_use),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural effect of one accepted op; lat is the expected busy length.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx  = longint'(signed'(x));
    sy  = longint'(signed'(y));
    ux  = x;
    uy  = y;
    lat = 0;
    case (o)
      3'd0: begin r = sx * sy; m_hi = r[63:32]; m_lo = r[31:0]; lat = 5; end
      3'd1: begin r = ux * uy; m_hi = r[63:32]; m_lo = r[31:0]; lat = 5; end
      3'd2: begin
        lat = 10;
        if (y != 0) begin
          r = sx / sy; m_lo = r[31:0];
          r = sx % sy; m_hi = r[31:0];
        end
      end
      3'd3: begin
        lat = 10;
        if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one op (caller is positioned just after a falling edge) and count
  // busy cycles. Returns at the falling edge of the first non-busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int nbusy);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    md_use = 1'b1; start = 1'b0;
    #1;
    n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    // A start held during reset must not write anything.
    start = 1'b1; op = 3'b100; a = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hold_hi: got %h want 0", hi); end
    reset = 1'b1; start = 1'b0; md_use = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [8] = '{3'd4, 3'd5, 3'd3, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
    logic [31:0] t_a  [8] = '{32'h11, 32'h22, 32'h1234, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] t_b  [8] = '{32'd0, 32'd0, 32'd0, 32'd5,
                              32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] e_hi [8] = '{32'h11, 32'h11, 32'h11, 32'hFFFF_FFFF,
                              32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] e_lo [8] = '{32'h0, 32'h22, 32'h22, 32'hFFFF_FFF1,
                              32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
    int          e_n  [8] = '{0, 0, 10, 5, 5, 10, 10, 10};
    int nb, lat;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], nb);
      model_op(t_op[i], t_a[i], t_b[i], lat);
      n_cmp++; if (nb !== e_n[i]) begin n_err++; $display("FAIL directed%0d_busy: got %0d cycles want %0d", i, nb, e_n[i]); end
      n_cmp++; if (hi !== e_hi[i]) begin n_err++; $display("FAIL directed%0d_hi: got %h want %h", i, hi, e_hi[i]); end
      n_cmp++; if (lo !== e_lo[i]) begin n_err++; $display("FAIL directed%0d_lo: got %h want %h", i, lo, e_lo[i]); end
    end
  endtask

  task automatic test_reserved();
    int nb;
    for (int k = 6; k < 8; k++) begin
      run_op(3'(k), $urandom, $urandom, nb);
      n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL reserved%0d_busy: got %0d cycles want 0", k, nb); end
      n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL reserved%0d_hilo: got %h/%h want %h/%h", k, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int nb, lat;
    logic [31:0] lo_before;
    run_op(3'b101, 32'h1234, 32'd0, nb);
    model_op(3'b101, 32'h1234, 32'd0, lat);
    lo_before = m_lo;
    md_use = 1'b1; start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL swb_stall_c0: got %b want 1", stall); end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = (cyc == 2); op = 3'b101; a = 32'hAAAA; b = 32'd0;
      #1;
      n_cmp++; if (stall !== (cyc <= 5)) begin n_err++; $display("FAIL swb_stall_c%0d: got %b want %b", cyc, stall, cyc <= 5); end
      if (cyc <= 5) begin
        n_cmp++; if (lo !== lo_before) begin n_err++; $display("FAIL swb_lo_c%0d: got %h want %h", cyc, lo, lo_before); end
      end
    end
    start = 1'b0; md_use = 1'b0;
    model_op(3'b000, 32'd2, 32'd3, lat);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL swb_busy_c6: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL swb_lo: got %h want 6", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL swb_hi: got %h want 0", hi); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nb, lat;
    logic [31:0] x, y;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom | 32'd1;
      run_op(3'(i), x, y, nb);   // next op starts in the cycle busy falls
      model_op(3'(i), x, y, lat);
      n_cmp++; if (nb !== lat) begin n_err++; $display("FAIL b2b%0d_busy: got %0d cycles want %0d", i, nb, lat); end
      n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL b2b%0d_hilo: got %h/%h want %h/%h", i, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random();
    int nb, lat;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
      run_op(o, x, y, nb);
      model_op(o, x, y, lat);
      n_cmp++; if (nb !== lat) begin n_err++; $display("FAIL rand%0d_busy op=%0d: got %0d cycles want %0d", i, o, nb, lat); end
      n_cmp++; if (hi !== m_hi) begin n_err++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, m_hi); end
      n_cmp++; if (lo !== m_lo) begin n_err++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, m_lo); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int nb, lat;
    run_op(3'b100, 32'hDEAD_0001, 32'd0, nb);
    run_op(3'b101, 32'hBEEF_0002, 32'd0, nb);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);   // now in busy cycle 4
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL rmid_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL rmid_lo: got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_after%0d_busy: got %b want 0", cyc, busy); end
    end
    n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL rmid_after_hilo: got %h/%h want 0/0", hi, lo);
    end
    // Unit must still work afterwards.
    run_op(3'b000, 32'd7, 32'd6, nb);
    model_op(3'b000, 32'd7, 32'd6, lat);
    n_cmp++; if (nb !== lat || lo !== m_lo) begin
      n_err++; $display("FAIL rmid_post_op: got %0d cycles lo=%h want %0d cycles lo=%h", nb, lo, lat, m_lo);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_directed();
    test_reserved();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit sequencer for the pipelined `mips` core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds the HI/LO architectural registers. It models a fixed multi-cycle latency with a busy counter. It also generates the stall request the hazard unit uses to freeze the D stage while an HI/LO-dependent instruction waits.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is an MDU op; valid for one cycle.
- `op`  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `md_use`  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `busy`  out  1  registered; a multi-cycle op is in flight.
- `stall`  out  1  combinational: `md_use & (busy | start)`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Two states:
  - IDLE: counter = 0, `busy` = 0.
  - RUN: counter ≠ 0, `busy` = 1.
- **IDLE, `start` = 1, op ∈ {000..011}:**
  - Latch the result pair into temp registers `t_hi`/`t_lo`, computed from `a`/`b` at that edge.
  - Load counter with MULT_CYCLES (ops 000/001) or DIV_CYCLES (ops 010/011).
  - Go to RUN.
- **IDLE, `start` = 1, op 100/101:** write `a` to HI or LO at that edge. No busy period.
- **IDLE, `start` = 1, op 110/111:** no effect.
- **RUN:** counter decrements each edge. On the edge where the counter goes 1 → 0:
  - `hi` ← `t_hi`, `lo` ← `t_lo`.
  - Return to IDLE.
- **`start` while RUN:** ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not occur; it is not an error condition.
- **Arithmetic:**
  - MULT: 64-bit signed product; HI = [63:32], LO = [31:0].
  - MULTU: unsigned product, same split.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- **Boundary cases:**
  - DIV `0x80000000 / 0xFFFFFFFF`: LO = 0x80000000, HI = 0x00000000.
  - Divide by zero (DIV or DIVU, `b` = 0): still busy for DIV_CYCLES; HI/LO keep their prior values at completion (temps load the current HI/LO).
- **Reset (`reset` = 0):** immediately, independent of clock:
  - `busy` = 0, counter = 0, temps = 0, `hi` = 0, `lo` = 0.
  - A reset mid-operation abandons the op; no partial write.

## Timing
- Cycle 0: `start` sampled. Cycles 1..N: `busy` = 1 (N = MULT_CYCLES or DIV_CYCLES).
- `hi`/`lo` show the new value from cycle N+1, the same cycle `busy` falls.
- A new op may start in cycle N+1.
- MTHI/MTLO: new value visible in cycle 1; `busy` stays 0.
- `stall` rises combinationally in cycle 0 if `md_use` = 1. It stays high through cycle N and falls in cycle N+1.
- Back-to-back legal sequence: start in cycle N+1 gives busy again in cycles N+2..2N+1.

## Test plan
- **MULT** `a` = 0xFFFFFFFD (−3), `b` = 5 → `busy` high exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **MULTU** `a` = 0xFFFFFFFF, `b` = 2 → HI = 0x00000001, LO = 0xFFFFFFFE after 5 busy cycles.
- **DIV** `a` = 0xFFFFFFF9 (−7), `b` = 2 → `busy` 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIVU** by zero with HI = 0x11, LO = 0x22 preloaded via MTHI/MTLO → `busy` 10 cycles; HI = 0x11, LO = 0x22 unchanged. Also DIV 0x80000000/−1 → LO = 0x80000000, HI = 0.
- **Start while busy:** MULT 2×3, then a second start (MTLO 0xAAAA) in busy cycle 2 → ignored; final LO = 6, HI = 0. With `md_use` = 1 held, `stall` = 1 from cycle 0 through cycle 5, and 0 in cycle 6.
- **Reset mid-operation:** DIV in flight, `reset` pulled low in busy cycle 4 between clock edges → `busy`, `hi`, `lo` go to 0 immediately. After release, counter stays 0 and no write occurs.
